fmap_collector: RTL and testbench
=================================

Name: fmap_collector

Overview:
- Upstream neighbour of the 14x13 feature-map register buffer.
- Accepts one signed accumulator result per cycle over a valid/ready stream, in raster order: row 0 col 0 … row H-1 col W-1.
- Saturates each result to DATA_WIDTH and writes it into an HxW tile.
- Pulses out_valid for one cycle when the tile is complete. That pulse drives the buffer's in_valid, and out_data drives its in_data.

Parameters:
- ACC_WIDTH, 32, width of signed input accumulator values.
- DATA_WIDTH, 24, width of signed stored/output elements.
- H, 14, tile rows.
- W, 13, tile columns.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input element valid.
- in_ready  output  1  collector can accept an element.
- in_data  input  ACC_WIDTH  signed accumulator element.
- in_last  input  1  sender marks final element of the frame.
- hold  input  1  stall request from the controller; forces in_ready low.
- out_valid  output  1  one-cycle pulse: tile complete.
- out_data  output  DATA_WIDTH x [0:H-1][0:W-1]  tile contents, unpacked 2-D array.
- frame_err  output  1  sticky framing-error flag.
- err_clr  input  1  synchronous clear of frame_err.

Behaviour:
- Reset (rst_n low, asynchronous):
  - row=0, col=0; out_valid=0; frame_err=0; every out_data element=0.
  - in_ready=0 while rst_n is low.
- in_ready = rst_n & ~hold. It is combinational and does not depend on out_valid, so there is no bubble between frames.
- Accept condition: in_valid & in_ready.
  - On accept, tile[row][col] <= sat(in_data).
  - col increments. At col=W-1 it wraps to 0 and row increments.
  - At row=H-1, col=W-1 both wrap to 0.
- sat() rule:
  - in_data > 2^(DATA_WIDTH-1)-1 gives 2^(DATA_WIDTH-1)-1.
  - in_data < -2^(DATA_WIDTH-1) gives -2^(DATA_WIDTH-1).
  - Otherwise the value is truncated to DATA_WIDTH bits, which preserves it exactly.
- Completion: out_valid=1 in the cycle after an accept where (row,col)=(H-1,W-1) and in_last=1. It is low in every other cycle.
- Latency:
  - Each element is visible on out_data 1 cycle after its accept.
  - out_valid asserts 1 cycle after the final accept.
- Back-to-back frames:
  - An element accepted during the out_valid cycle writes tile[0][0] at the end of that cycle.
  - The downstream buffer samples the completed tile at that same edge, so no data loss.
- Framing errors:
  - in_last=1 on accept at any position other than (H-1,W-1): frame_err<=1, row/col reset to 0, no out_valid. Tile elements already written are not cleared.
  - in_last=0 on accept at (H-1,W-1): frame_err<=1, counters wrap to 0 normally, no out_valid.
- err_clr=1 clears frame_err next edge. A new error in the same cycle wins, so frame_err stays 1.
- in_valid while in_ready=0: ignored; the sender holds its element.
- Reset mid-frame: partial frame discarded; counters and tile return to 0.

Optional Feature:
- Macro: FMAP_COLLECTOR_RELU_EN.
- Defined: negative in_data is stored as 0 (ReLU), applied before saturation; positive saturation is unchanged.
- Undefined: signed saturation only; negative values are preserved.

Test Plan:
- Reset, then stream 182 elements with in_data=k (k=0..181) and in_last on element 181, hold=0 → out_valid single pulse 1 cycle after the last accept; out_data[r][c]=13r+c; frame_err=0.
- Element values 0x00900000 and 0xFF000000 (−16777216) at positions (0,0) and (0,1) → out_data[0][0]=0x7FFFFF, out_data[0][1]=0x800000. With FMAP_COLLECTOR_RELU_EN defined, out_data[0][1]=0.
- Assert hold for 5 cycles mid-frame while in_valid=1 → in_ready=0, no accepts, position unchanged; frame completes after release with correct contents.
- in_last=1 on element 50 → frame_err=1, no out_valid; next 182-element frame completes with out_valid and correct data. Then pulse err_clr → frame_err=0.
- Two frames back-to-back with no idle cycle (frame 2 values = 1000+k) → two out_valid pulses 182 cycles apart; first-frame values are present on out_data in the cycle out_valid is high, before frame 2 overwrites them.
- rst_n low for 1 cycle after element 100 → all outputs 0; a following full frame completes correctly with the counters starting at (0,0).

Source files
------------

// File: rtl/fmap_collector.sv
// fmap_collector
//   Collects one signed accumulator result per accepted beat, in raster order,
//   saturates it to DATA_WIDTH and stores it into an H x W tile. Pulses
//   out_valid for one cycle when a correctly framed tile is complete.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     input element valid
//   in_ready     collector can accept (combinational: rst_n & ~hold)
//   in_data      signed accumulator element (ACC_WIDTH)
//   in_last      sender marks final element of the frame
//   hold         stall request, forces in_ready low
//   out_valid    one-cycle pulse, tile complete
//   out_data     tile contents [0:H-1][0:W-1], signed DATA_WIDTH each
//   frame_err    sticky framing-error flag
//   err_clr      synchronous clear of frame_err
//
// Build option:
//   FMAP_COLLECTOR_RELU_EN  when defined, negative inputs are stored as 0.
module fmap_collector #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned H          = 14,
  parameter int unsigned W          = 13
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [ACC_WIDTH-1:0]  in_data,
  input  logic                         in_last,
  input  logic                         hold,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data [0:H-1][0:W-1],
  output logic                         frame_err,
  input  logic                         err_clr
);

  localparam int unsigned ROW_W = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned COL_W = (W > 1) ? $clog2(W) : 1;
  // Input bits from the result sign bit upwards; all equal means no overflow.
  localparam int unsigned EXT_W = ACC_WIDTH - DATA_WIDTH + 1;

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic signed [DATA_WIDTH-1:0] tile_q [0:H-1][0:W-1];

  logic                         accept;
  logic                         at_end;
  logic                         col_end;
  logic                         err_set;
  logic [EXT_W-1:0]             upper;
  logic signed [DATA_WIDTH-1:0] sat_val;

  assign in_ready = rst_n & ~hold;
  assign accept   = in_valid & in_ready;
  assign upper    = in_data[ACC_WIDTH-1 -: EXT_W];

  // Saturate (and optionally rectify) the incoming accumulator value.
  always_comb begin
    sat_val = in_data[DATA_WIDTH-1:0];
    if (in_data[ACC_WIDTH-1]) begin
`ifdef FMAP_COLLECTOR_RELU_EN
      sat_val = '0;
`else
      if (upper != '1) sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif
    end else if (upper != '0) begin
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  // Raster position, completion and framing-error next state.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = 1'b0;
    err_set     = 1'b0;
    col_end     = (col_q == COL_W'(W - 1));
    at_end      = (row_q == ROW_W'(H - 1)) && col_end;
    if (accept) begin
      if (in_last && !at_end) begin
        // Early last: abandon the frame and restart at the origin.
        row_d   = '0;
        col_d   = '0;
        err_set = 1'b1;
      end else if (at_end) begin
        row_d       = '0;
        col_d       = '0;
        out_valid_d = in_last;
        err_set     = ~in_last;
      end else if (col_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
    // A new error in the same cycle as a clear keeps the flag set.
    frame_err_d = err_set | (frame_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Tile storage: the accepted element lands at the current raster position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < H; r++) begin
        for (int unsigned c = 0; c < W; c++) begin
          tile_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int unsigned r = 0; r < H; r++) begin
        for (int unsigned c = 0; c < W; c++) begin
          if ((row_q == ROW_W'(r)) && (col_q == COL_W'(c))) begin
            tile_q[r][c] <= sat_val;
          end
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign out_data  = tile_q;

endmodule

// File: tb/tb_fmap_collector.sv
// Testbench for fmap_collector: randomized frames against a behavioural
// tile model; completed tiles are queued and checked when out_valid pulses.
module tb_fmap_collector;

  localparam int ACC_W = 32;
  localparam int DW    = 24;
  localparam int H     = 14;
  localparam int W     = 13;
  localparam int N     = H * W;
  localparam longint SMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (DW - 1));

  typedef logic [N*DW-1:0] flat_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_data = '0;
  logic                    in_last = 1'b0;
  logic                    hold = 1'b0;
  logic                    out_valid;
  logic signed [DW-1:0]    out_data [0:H-1][0:W-1];
  logic                    frame_err;
  logic                    err_clr = 1'b0;

  fmap_collector #(.ACC_WIDTH(ACC_W), .DATA_WIDTH(DW), .H(H), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .hold(hold), .out_valid(out_valid),
    .out_data(out_data), .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     passed = 0;
  longint cyc = 0;
  bit     hold_req = 1'b0;

  // Reference model state
  longint m_tile [0:H-1][0:W-1];
  int     m_row = 0;
  int     m_col = 0;
  bit     m_err = 1'b0;
  flat_t  exp_q[$];
  longint pulse_cyc[$];
  flat_t  mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) m_tile[r][c] = 0;
    m_row = 0;
    m_col = 0;
    m_err = 1'b0;
  endtask

  function automatic flat_t pack_model();
    flat_t f = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) f[(r*W+c)*DW +: DW] = DW'(m_tile[r][c]);
    return f;
  endfunction

  // Element arrival in the model: clamp, store, then advance/raise error.
  task automatic model_accept(input logic [ACC_W-1:0] d, input bit last, output bit e);
    longint v = longint'($signed(d));
    bit at_end = (m_row == H - 1) && (m_col == W - 1);
    e = 1'b0;
`ifdef FMAP_COLLECTOR_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > SMAX) v = SMAX;
    else if (v < SMIN) v = SMIN;
    m_tile[m_row][m_col] = v;
    if (last && at_end) begin
      exp_q.push_back(pack_model());
      m_row = 0; m_col = 0;
    end else if (last) begin
      e = 1'b1; m_row = 0; m_col = 0;
    end else if (at_end) begin
      e = 1'b1; m_row = 0; m_col = 0;
    end else if (m_col == W - 1) begin
      m_col = 0; m_row++;
    end else begin
      m_col++;
    end
  endtask

  task automatic check_tile(input string name);
    int bad = -1;
    longint a = 0, x = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (bad < 0 && longint'(out_data[r][c]) != longint'($signed(DW'(m_tile[r][c])))) begin
          bad = r * W + c;
          a = longint'(out_data[r][c]);
          x = m_tile[r][c];
        end
    checks++;
    if (bad < 0) passed++;
    else $display("FAIL %s: element %0d got %0d expected %0d (cycle %0d)", name, bad, a, x, cyc);
  endtask

  // One clock of stimulus; checks the state produced by earlier edges first.
  task automatic do_cycle(input bit v, input logic [ACC_W-1:0] d, input bit last, input bit clr);
    bit e;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = last; err_clr = clr; hold = hold_req;
    #1;
    chk("in_ready", longint'(in_ready), longint'(rst_n && !hold));
    chk("frame_err", longint'(frame_err), longint'(m_err));
    check_tile("tile contents");
    e = 1'b0;
    if (v && rst_n && !hold) model_accept(d, last, e);
    if (e) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0;
    #1;
    chk("reset in_ready", longint'(in_ready), 0);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset frame_err", longint'(frame_err), 0);
    model_clear();
    check_tile("reset tile");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [ACC_W-1:0] gen(input int kind, input int base, input int i);
    logic [ACC_W-1:0] r = $urandom;
    if (kind == 0) return ACC_W'(base + i);
    if (kind == 2 && i == 0) return 32'h0090_0000;
    if (kind == 2 && i == 1) return 32'hFF00_0000;
    case ($urandom_range(3))
      0: return r;
      1: return ACC_W'(int'($urandom_range(2000)) - 1000);
      2: case ($urandom_range(5))
           0: return ACC_W'(SMAX);
           1: return ACC_W'(SMAX + 1);
           2: return ACC_W'(SMIN);
           3: return ACC_W'(SMIN - 1);
           4: return '0;
           default: return '1;
         endcase
      default: return {{(ACC_W-DW){r[DW-1]}}, r[DW-1:0]};
    endcase
  endfunction

  task automatic send_frame(input int n, input int kind, input int base, input int last_idx,
                            input bit gaps, input int hold_at, input int clr_idx);
    logic [ACC_W-1:0] val;
    for (int i = 0; i < n; i++) begin
      val = gen(kind, base, i);
      if (gaps)
        while ($urandom_range(3) == 0) do_cycle(1'b0, $urandom, 1'($urandom_range(1)), 1'b0);
      if (i == hold_at) begin
        hold_req = 1'b1;
        repeat (5) do_cycle(1'b1, val, i == last_idx, 1'b0);
        chk("hold position row", m_row, i / W);
        chk("hold position col", m_col, i % W);
        hold_req = 1'b0;
      end
      do_cycle(1'b1, val, i == last_idx, i == clr_idx);
    end
  endtask

  // Scoreboard monitor: each out_valid pulse must match the oldest queued tile.
  always @(negedge clk) begin
    cyc++;
    if (out_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        int bad = -1;
        longint a = 0, x = 0;
        mon_e = exp_q.pop_front();
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++)
            if (bad < 0 && out_data[r][c] !== mon_e[(r*W+c)*DW +: DW]) begin
              bad = r * W + c;
              a = longint'(out_data[r][c]);
              x = longint'($signed(mon_e[(r*W+c)*DW +: DW]));
            end
        checks++;
        if (bad < 0) passed++;
        else $display("FAIL completed tile: element %0d got %0d expected %0d (cycle %0d)", bad, a, x, cyc);
      end
    end
  end

  initial begin
    model_clear();
    do_reset();

    // Ramp frame 0..181
    pulse_cyc.delete();
    send_frame(N, 0, 0, N - 1, 1'b0, -1, -1);
    repeat (3) do_cycle(1'b0, '0, 1'b0, 1'b0);
    chk("ramp pulse count", pulse_cyc.size(), 1);
    chk("ramp element [5][7]", longint'(out_data[5][7]), 72);
    chk("ramp element [13][12]", longint'(out_data[13][12]), 181);

    // Saturation frame with random fill
    send_frame(N, 2, 0, N - 1, 1'b1, -1, -1);
    do_cycle(1'b0, '0, 1'b0, 1'b0);
    chk("positive saturation", longint'(out_data[0][0]), SMAX);
`ifdef FMAP_COLLECTOR_RELU_EN
    chk("negative rectified", longint'(out_data[0][1]), 0);
`else
    chk("negative saturation", longint'(out_data[0][1]), SMIN);
`endif

    // Hold mid-frame
    send_frame(N, 1, 0, N - 1, 1'b1, 60, -1);

    // Early last on element 50, then a good frame, then clear
    send_frame(51, 1, 0, 50, 1'b1, -1, -1);
    repeat (2) do_cycle(1'b0, '0, 1'b0, 1'b0);
    chk("early-last error", longint'(frame_err), 1);
    send_frame(N, 1, 0, N - 1, 1'b1, -1, -1);
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (2) do_cycle(1'b0, '0, 1'b0, 1'b0);
    chk("error cleared", longint'(frame_err), 0);

    // Missing last with a clear in the same cycle: the error must win
    send_frame(N, 1, 0, -1, 1'b0, -1, N - 1);
    do_cycle(1'b0, '0, 1'b0, 1'b0);
    chk("missing-last error", longint'(frame_err), 1);
    do_cycle(1'b0, '0, 1'b0, 1'b1);

    // Back-to-back frames
    pulse_cyc.delete();
    send_frame(N, 0, 0, N - 1, 1'b0, -1, -1);
    send_frame(N, 0, 1000, N - 1, 1'b0, -1, -1);
    repeat (3) do_cycle(1'b0, '0, 1'b0, 1'b0);
    chk("b2b pulse count", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2) chk("b2b pulse spacing", pulse_cyc[1] - pulse_cyc[0], N);
    chk("b2b frame2 [0][0]", longint'(out_data[0][0]), 1000);

    // Reset after element 100, then a full frame from the origin
    send_frame(101, 0, 0, -1, 1'b1, -1, -1);
    do_reset();
    send_frame(N, 0, 500, N - 1, 1'b1, -1, -1);
    repeat (3) do_cycle(1'b0, '0, 1'b0, 1'b0);
    chk("post-reset [0][0]", longint'(out_data[0][0]), 500);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
